lsu_mem: RTL

Load/store unit directly downstream of the `exec` stage. It consumes the data-memory address `res_brt_dma` computed by `exec`, together with the store data and access width for the instruction. It drives a single-port, word-wide data memory through a request/acknowledge handshake, aligns and extends load data, and returns one writeback beat per load. Misaligned or illegal accesses are flagged instead of issued.

---
 rtl/lsu_mem.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lsu_mem.sv
// lsu_mem: load/store unit between exec and a single-port word-wide data memory
//   clk, rst                : clock, async active-high reset
//   ls_v/we/f3/addr/sd/rd   : op from exec; ls_rdy accepts it
//   dm_req/we/addr/be/wd    : memory request, held until dm_ack; dm_rd read data
//   wb_v/rd/d               : one-cycle load writeback
//   ls_err/err_addr         : one-cycle misaligned/illegal flag with byte address
module lsu_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        ls_v,
    input  logic        ls_we,
    input  logic [2:0]  ls_f3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_sd,
    input  logic [4:0]  ls_rd,
    output logic        ls_rdy,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wd,
    input  logic        dm_ack,
    input  logic [31:0] dm_rd,
    output logic        wb_v,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_d,
    output logic        ls_err,
    output logic [31:0] err_addr
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state_q, state_d;
    logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d, wb_v_q, wb_v_d, ls_err_q, ls_err_d;
    logic [31:0] dm_addr_q, dm_addr_d, dm_wd_q, dm_wd_d, wb_d_q, wb_d_d, err_addr_q, err_addr_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  k_q, k_d;
    logic        bad;
    logic [3:0]  be;
    logic [31:0] wd, sh, ext;
    assign ls_rdy = (state_q == IDLE) & ~rst;
    // f3[1:0] encodes the width (00 byte, 01 half, 10 word); f3[2] marks unsigned loads
    assign bad = (ls_f3 == 3'b011) | (ls_f3 == 3'b110) | (ls_f3 == 3'b111) | (ls_we & ls_f3[2])
               | ((ls_f3[1:0] == 2'b01) & ls_addr[0]) | ((ls_f3 == 3'b010) & (ls_addr[1:0] != 2'b00));
    assign be  = ls_f3[1] ? 4'b1111 : ls_f3[0] ? 4'b0011 << ls_addr[1:0] : 4'b0001 << ls_addr[1:0];
    assign wd  = ~ls_we ? 32'h0 : ls_f3[1] ? ls_sd : ls_f3[0] ? {2{ls_sd[15:0]}} : {4{ls_sd[7:0]}};
    assign sh  = dm_rd >> {k_q, 3'b000};
    assign ext = (f3_q == 3'b000) ? {{24{sh[7]}}, sh[7:0]}
               : (f3_q == 3'b001) ? {{16{sh[15]}}, sh[15:0]}
               : (f3_q == 3'b100) ? {24'h0, sh[7:0]}
               : (f3_q == 3'b101) ? {16'h0, sh[15:0]} : dm_rd;
    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_be_d    = dm_be_q;
        dm_wd_d    = dm_wd_q;
        wb_rd_d    = wb_rd_q;
        wb_d_d     = wb_d_q;
        err_addr_d = err_addr_q;
        f3_d       = f3_q;
        k_d        = k_q;
        wb_v_d     = 1'b0;
        ls_err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (ls_v & ls_rdy & bad) begin
                ls_err_d   = 1'b1;
                err_addr_d = ls_addr;
            end else if (ls_v & ls_rdy) begin
                state_d   = WAIT;
                dm_req_d  = 1'b1;
                dm_we_d   = ls_we;
                dm_addr_d = {ls_addr[31:2], 2'b00};
                dm_be_d   = be;
                dm_wd_d   = wd;
                wb_rd_d   = ls_rd;
                f3_d      = ls_f3;
                k_d       = ls_addr[1:0];
            end
        end else if (dm_ack) begin
            state_d  = IDLE;
            dm_req_d = 1'b0;
            wb_v_d   = ~dm_we_q;
            wb_d_d   = dm_we_q ? wb_d_q : ext;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_be_q    <= '0;
            dm_wd_q    <= '0;
            wb_v_q     <= 1'b0;
            wb_rd_q    <= '0;
            wb_d_q     <= '0;
            ls_err_q   <= 1'b0;
            err_addr_q <= '0;
            f3_q       <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_be_q    <= dm_be_d;
            dm_wd_q    <= dm_wd_d;
            wb_v_q     <= wb_v_d;
            wb_rd_q    <= wb_rd_d;
            wb_d_q     <= wb_d_d;
            ls_err_q   <= ls_err_d;
            err_addr_q <= err_addr_d;
            f3_q       <= f3_d;
            k_q        <= k_d;
        end
    end
    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_be    = dm_be_q;
    assign dm_wd    = dm_wd_q;
    assign wb_v     = wb_v_q;
    assign wb_rd    = wb_rd_q;
    assign wb_d     = wb_d_q;
    assign ls_err   = ls_err_q;
    assign err_addr = err_addr_q;
endmodule
